fp_mul_pipe: RTL
================

# fp_mul_pipe

Parametrised, pipelined IEEE-754-style floating-point multiplier with valid/ready handshaking, five rounding modes and exception flags. It supersedes the single-precision combinational multiplier in the ALU datapath. Exponent and fraction widths are generic, so one block serves binary32, binary16 and bfloat16 lanes. It sits between the ALU operand-issue stage and the result-writeback arbiter.

## Interface
- EXP_W, 8, exponent field width (≥3); BIAS = 2^(EXP_W-1)-1
- FRC_W, 23, stored fraction width (≥2); W = 1+EXP_W+FRC_W
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- fp_X, fp_Y  in  W  operands {sign, exp, frac}
- r_mode  in  3  rounding mode, captured with operands
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- fp_Z  out  W  product
- ovrf, udrf, nv  out  1 each  overflow, underflow, invalid; qualified by out_valid

## Operation
- Operand classes: exp==0 → ZERO (subnormals flush to zero, sign kept); exp all-ones, frac==0 → INF; exp all-ones, frac≠0 → NaN (sNaN if frac MSB=0).
- sign_Z = sign_X ^ sign_Y for all non-NaN results.
- Specials, in priority order:
  - any NaN → canonical qNaN {0, all-ones, 1, zeros}; nv=1 iff an sNaN is present.
  - ZERO×INF → canonical qNaN, nv=1.
  - INF×anything else → signed INF.
  - ZERO×finite → signed zero.
  - No special case sets ovrf or udrf.
- Normal path:
  - Product {1,fX}×{1,fY} is 2·FRC_W+2 bits.
  - If the product MSB is set, exponent +1; otherwise shift left 1.
  - Keep hidden+FRC_W bits, then guard, round, sticky = OR of the remaining bits.
  - Biased exponent = eX+eY-BIAS(+1 if MSB set), computed in EXP_W+2 signed bits.
- Rounding (inc = mantissa increment):
  - 000 RNE: G & (R|S|L), where L = kept LSB.
  - 001 RTZ: never.
  - 010 RDN: sign & (G|R|S).
  - 011 RUP: !sign & (G|R|S).
  - 100 RMM: G.
  - 101–111 behave as RNE.
  - A mantissa carry-out gives fraction 0 and exponent +1.
- Underflow: pre-round biased exp ≤ 0 → signed zero, udrf=1.
- Overflow: post-round biased exp ≥ 2^EXP_W-1 → ovrf=1.
  - Result is signed INF for RNE/RMM, for RUP when positive and for RDN when negative.
  - Otherwise the result is signed max finite {all-ones−1, all-ones}.

## Timing
- Three stages:
  - S1: classify and multiply.
  - S2: normalise, exponent, sticky.
  - S3: round, pack, flags.
- Latency is exactly 3 cycles from an accepted input (in_valid & in_ready) to out_valid, with no back-pressure.
- Throughput is 1 per cycle.
- advance = !out_valid | out_ready.
  - in_ready = advance (combinational).
  - All stages shift together only when advance=1.
  - Stage valid bits propagate; bubbles are preserved and not collapsed.
- While out_valid & !out_ready, fp_Z/ovrf/udrf/nv are held stable and no stage moves.
- Simultaneous output accept and input accept in the same cycle are both honoured.
- Reset (async, any cycle): all stage valids, out_valid, fp_Z and flags go to 0. In-flight operations are discarded. in_ready is 1 after release.
- r_mode travels with its operands; changing it mid-flight does not affect earlier ops.

## Structure
- Package fp_mul_pkg holds:
  - r_mode enum (RNE, RTZ, RDN, RUP, RMM).
  - Operand-class enum (ZERO, NORM, INF, NAN).
  - Parametrised canonical-NaN and max-finite constant functions.
- Sub-module fp_mul_round is combinational S3 logic: GRS → inc, carry, overflow/underflow selection and packing.
- The pipeline registers and handshake live in fp_mul_pipe.

## Test plan
- Default params:
  - 0x40400000×0x40400000, RTZ → 0x41100000, no flags, after 3 cycles.
  - 0x3F800001×0x3F800001: RTZ → 0x3F800002, RUP → 0x3F800003, RNE → 0x3F800002, RDN with fp_X=0xBF800001 → 0xBF800003.
- 0x7F000000×0x7F000000: RNE → 0x7F800000 ovrf=1; RTZ → 0x7F7FFFFF ovrf=1.
- 0x00800000×0x00800000 → 0x00000000 udrf=1; 0x80000000×0x7F800000 → 0x7FC00000 nv=1; 0x7F800001×0x3F800000 → 0x7FC00000 nv=1.
- Stream 8 back-to-back ops with out_ready toggling 1,0,0,1: results appear in order, none lost or duplicated, and fp_Z is stable while stalled.
- Assert rst with 2 ops in flight: out_valid=0 immediately, and no stale result appears after release.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared types and constant helpers for the pipelined floating-point multiplier.
// Constant helpers return a 64-bit image; callers size-cast to their word width.
package fp_mul_pkg;

   typedef enum logic [2:0] {
      RmRne = 3'd0,
      RmRtz = 3'd1,
      RmRdn = 3'd2,
      RmRup = 3'd3,
      RmRmm = 3'd4
   } rmode_e;

   typedef enum logic [1:0] {
      ClsZero,
      ClsNorm,
      ClsInf,
      ClsNan
   } fp_class_e;

   localparam int unsigned MaxW = 64;

   // Quiet NaN: sign 0, exponent all ones, fraction MSB set.
   function automatic logic [MaxW-1:0] canon_nan(input int unsigned exp_w,
                                                 input int unsigned frc_w);
      return (((64'd1 << exp_w) - 64'd1) << frc_w) | (64'd1 << (frc_w - 1));
   endfunction

   // Largest finite magnitude: exponent all-ones minus one, fraction all ones.
   function automatic logic [MaxW-1:0] max_finite(input int unsigned exp_w,
                                                  input int unsigned frc_w);
      return (((64'd1 << exp_w) - 64'd2) << frc_w) | ((64'd1 << frc_w) - 64'd1);
   endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Final multiplier stage: rounding increment, carry, overflow/underflow selection and
// result packing. Purely combinational.
module fp_mul_round
   import fp_mul_pkg::*;
#(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned FRC_W = 23,
   localparam int unsigned W = 1 + EXP_W + FRC_W
) (
   input  logic               sign,
   input  logic [EXP_W+1:0]   exp_b,
   input  logic [FRC_W-1:0]   frac,
   input  logic               g,
   input  logic               r,
   input  logic               s,
   input  logic [2:0]         r_mode,
   input  logic               special,
   input  logic [W-1:0]       special_z,
   input  logic               special_nv,
   output logic [W-1:0]       z,
   output logic               ovrf,
   output logic               udrf,
   output logic               nv
);

   localparam logic [EXP_W-1:0] ExpOnes = '1;
   localparam logic [W-1:0]     MaxFin  = W'(max_finite(EXP_W, FRC_W));

   logic             inc;
   logic             ovf_inf;
   logic             carry;
   logic [FRC_W:0]   mant_r;
   logic [EXP_W+1:0] exp_r;
   logic [FRC_W-1:0] frac_r;
   logic             under;
   logic             over;

   always_comb begin
      inc     = g & (r | s | frac[0]);
      ovf_inf = 1'b1;
      case (r_mode)
         RmRtz: begin
            inc     = 1'b0;
            ovf_inf = 1'b0;
         end
         RmRdn: begin
            inc     = sign & (g | r | s);
            ovf_inf = sign;
         end
         RmRup: begin
            inc     = !sign & (g | r | s);
            ovf_inf = !sign;
         end
         RmRmm:   inc = g;
         default: ;
      endcase
   end

   // Hidden bit wraps to zero exactly when the increment carries out of the mantissa.
   assign mant_r = {1'b1, frac} + {{FRC_W{1'b0}}, inc};
   assign carry  = !mant_r[FRC_W];
   assign frac_r = carry ? '0 : mant_r[FRC_W-1:0];
   assign exp_r  = exp_b + {{(EXP_W+1){1'b0}}, carry};

   assign under = exp_b[EXP_W+1] | (exp_b == '0);
   assign over  = exp_r >= {2'b00, ExpOnes};

   always_comb begin
      z    = {sign, exp_r[EXP_W-1:0], frac_r};
      ovrf = 1'b0;
      udrf = 1'b0;
      nv   = 1'b0;
      if (special) begin
         z  = special_z;
         nv = special_nv;
      end else if (under) begin
         z    = '0;
         z[W-1] = sign;
         udrf = 1'b1;
      end else if (over) begin
         ovrf = 1'b1;
         z    = ovf_inf ? {sign, ExpOnes, {FRC_W{1'b0}}} : {sign, MaxFin[W-2:0]};
      end
   end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control.
// S1 classifies and multiplies, S2 normalises, S3 (fp_mul_round) rounds into the output register.
module fp_mul_pipe
   import fp_mul_pkg::*;
#(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned FRC_W = 23,
   localparam int unsigned W = 1 + EXP_W + FRC_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] fp_X,
   input  logic [W-1:0] fp_Y,
   input  logic [2:0]   r_mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] fp_Z,
   output logic         ovrf,
   output logic         udrf,
   output logic         nv
);

   localparam int unsigned PW = 2 * FRC_W + 2;
   localparam int unsigned EW = EXP_W + 2;
   localparam logic [EW-1:0]    BiasE   = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic [EXP_W-1:0] ExpOnes = '1;
   localparam logic [W-1:0]     NanZ    = W'(canon_nan(EXP_W, FRC_W));

   function automatic fp_class_e classify(input logic [EXP_W-1:0] e,
                                          input logic [FRC_W-1:0] f);
      if (e == '0) return ClsZero;
      if (e == ExpOnes) return (f == '0) ? ClsInf : ClsNan;
      return ClsNorm;
   endfunction

   logic advance;
   assign advance  = !out_valid | out_ready;
   assign in_ready = advance;

   // ---------------- S1: classify and multiply ----------------
   logic             sx, sy;
   logic [EXP_W-1:0] ex, ey;
   logic [FRC_W-1:0] fx, fy;
   fp_class_e        cx, cy;
   logic             sign1_d;
   logic [EW-1:0]    esum1_d;
   logic [PW-1:0]    prod1_d;
   logic             spc1_d;
   logic [W-1:0]     spz1_d;
   logic             spnv1_d;

   assign {sx, ex, fx} = fp_X;
   assign {sy, ey, fy} = fp_Y;
   assign cx = classify(ex, fx);
   assign cy = classify(ey, fy);

   always_comb begin
      sign1_d = sx ^ sy;
      esum1_d = {2'b00, ex} + {2'b00, ey} - BiasE;
      prod1_d = PW'({1'b1, fx}) * PW'({1'b1, fy});
      spc1_d  = 1'b1;
      spz1_d  = '0;
      spnv1_d = 1'b0;
      if (cx == ClsNan || cy == ClsNan) begin
         spz1_d  = NanZ;
         spnv1_d = (cx == ClsNan && !fx[FRC_W-1]) || (cy == ClsNan && !fy[FRC_W-1]);
      end else if ((cx == ClsZero && cy == ClsInf) || (cx == ClsInf && cy == ClsZero)) begin
         spz1_d  = NanZ;
         spnv1_d = 1'b1;
      end else if (cx == ClsInf || cy == ClsInf) begin
         spz1_d = {sign1_d, ExpOnes, {FRC_W{1'b0}}};
      end else if (cx == ClsZero || cy == ClsZero) begin
         spz1_d = {sign1_d, {(W-1){1'b0}}};
      end else begin
         spc1_d = 1'b0;
      end
   end

   logic          v1_q, sign1_q, spc1_q, spnv1_q;
   logic [EW-1:0] esum1_q;
   logic [PW-1:0] prod1_q;
   logic [2:0]    rm1_q;
   logic [W-1:0]  spz1_q;

   // ---------------- S2: normalise, exponent, sticky ----------------
   logic          msb;
   logic [PW-2:0] norm;
   assign msb  = prod1_q[PW-1];
   // Drop the hidden one: with msb set it sits at PW-1, otherwise at PW-2.
   assign norm = msb ? prod1_q[PW-2:0] : {prod1_q[PW-3:0], 1'b0};

   logic             v2_q, sign2_q, g2_q, r2_q, s2_q, spc2_q, spnv2_q;
   logic [EW-1:0]    exp2_q;
   logic [FRC_W-1:0] frac2_q;
   logic [2:0]       rm2_q;
   logic [W-1:0]     spz2_q;

   // ---------------- S3: round and pack ----------------
   logic [W-1:0] z3;
   logic         ovrf3, udrf3, nv3;

   fp_mul_round #(
      .EXP_W(EXP_W),
      .FRC_W(FRC_W)
   ) u_round (
      .sign      (sign2_q),
      .exp_b     (exp2_q),
      .frac      (frac2_q),
      .g         (g2_q),
      .r         (r2_q),
      .s         (s2_q),
      .r_mode    (rm2_q),
      .special   (spc2_q),
      .special_z (spz2_q),
      .special_nv(spnv2_q),
      .z         (z3),
      .ovrf      (ovrf3),
      .udrf      (udrf3),
      .nv        (nv3)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q      <= 1'b0;
         sign1_q   <= 1'b0;
         esum1_q   <= '0;
         prod1_q   <= '0;
         rm1_q     <= '0;
         spc1_q    <= 1'b0;
         spz1_q    <= '0;
         spnv1_q   <= 1'b0;
         v2_q      <= 1'b0;
         sign2_q   <= 1'b0;
         exp2_q    <= '0;
         frac2_q   <= '0;
         g2_q      <= 1'b0;
         r2_q      <= 1'b0;
         s2_q      <= 1'b0;
         rm2_q     <= '0;
         spc2_q    <= 1'b0;
         spz2_q    <= '0;
         spnv2_q   <= 1'b0;
         out_valid <= 1'b0;
         fp_Z      <= '0;
         ovrf      <= 1'b0;
         udrf      <= 1'b0;
         nv        <= 1'b0;
      end else if (advance) begin
         v1_q    <= in_valid;
         sign1_q <= sign1_d;
         esum1_q <= esum1_d;
         prod1_q <= prod1_d;
         rm1_q   <= r_mode;
         spc1_q  <= spc1_d;
         spz1_q  <= spz1_d;
         spnv1_q <= spnv1_d;

         v2_q    <= v1_q;
         sign2_q <= sign1_q;
         exp2_q  <= esum1_q + {{(EW-1){1'b0}}, msb};
         frac2_q <= norm[PW-2:FRC_W+1];
         g2_q    <= norm[FRC_W];
         r2_q    <= norm[FRC_W-1];
         s2_q    <= |norm[FRC_W-2:0];
         rm2_q   <= rm1_q;
         spc2_q  <= spc1_q;
         spz2_q  <= spz1_q;
         spnv2_q <= spnv1_q;

         out_valid <= v2_q;
         if (v2_q) begin
            fp_Z <= z3;
            ovrf <= ovrf3;
            udrf <= udrf3;
            nv   <= nv3;
         end
      end
   end

endmodule
